// File: rtl/seg7_display_driver_pkg.sv
// Shared constants for the 8-digit hex display driver: bus address codes,
// digit count and the 7-segment glyph table.
package seg7_display_driver_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int IDX_W      = $clog2(NUM_DIGITS);
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {
      DISP_ADDR_WORD = 2'b00,
      DISP_ADDR_LO   = 2'b01,
      DISP_ADDR_HI   = 2'b10,
      DISP_ADDR_RSVD = 2'b11
   } disp_addr_e;

   // Segment order {dp,g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
   localparam logic [15:0][7:0] SEG7_LUT = {
      8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
      8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

endpackage

// File: rtl/seg7_display_driver_if.sv
// CPU-side write port of the display block; the CPU is master, the driver is slave.
interface seg7_display_driver_if;

   logic                                     disp_cs;
   logic                                     disp_wen;
   logic [1:0]                               disp_addr;
   logic [seg7_display_driver_pkg::DATA_W-1:0] disp_wdata;
   logic [seg7_display_driver_pkg::DATA_W-1:0] disp_data;

   modport master (
      output disp_cs, disp_wen, disp_addr, disp_wdata,
      input  disp_data
   );

   modport slave (
      input  disp_cs, disp_wen, disp_addr, disp_wdata,
      output disp_data
   );

endinterface

// File: rtl/seg7_display_driver_hex_to_seg7.sv
// Combinational hex nibble to 7-segment glyph; dp is never lit.
module hex_to_seg7
   import seg7_display_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] seg
);

   assign seg = SEG7_LUT[nibble];

endmodule

// File: rtl/seg7_display_driver.sv
// Latches the CPU display word and scans it as 8 hex digits onto a shared
// 7-segment bus with one-hot digit select and optional leading-zero blanking.
//
// Scan state:
//   scan_cnt  | dwell position within the current digit (0..SCAN_DIV-1)
//   digit_idx | digit being prepared for the output registers (0 = rightmost)
module seg7_display_driver
   import seg7_display_driver_pkg::*;
#(
   parameter int SCAN_DIV = 20000,
   parameter int CNT_W    = 15
)
(
   input  logic                  clk,
   input  logic                  rst,
   seg7_display_driver_if.slave  bus,
   input  logic                  blank_en,
   output logic [NUM_DIGITS-1:0] digit_sel,
   output logic [7:0]            seg
);

   logic [CNT_W-1:0]      scan_cnt, scan_cnt_nxt;
   logic [IDX_W-1:0]      digit_idx, digit_idx_nxt;
   logic [DATA_W-1:0]     data_q, data_nxt;
   logic [NUM_DIGITS-1:0] digit_sel_nxt;
   logic [7:0]            seg_nxt;
   logic [7:0]            seg_enc;
   logic [3:0]            nibble;
   logic                  blank;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
         data_q    <= '0;
         digit_sel <= '0;
         seg       <= '0;
      end else begin
         scan_cnt  <= scan_cnt_nxt;
         digit_idx <= digit_idx_nxt;
         data_q    <= data_nxt;
         digit_sel <= digit_sel_nxt;
         seg       <= seg_nxt;
      end
   end

   always_comb begin
      scan_cnt_nxt  = scan_cnt + CNT_W'(1);
      digit_idx_nxt = digit_idx;
      data_nxt      = data_q;
      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt_nxt  = '0;
         digit_idx_nxt = digit_idx + IDX_W'(1);
      end
      if (bus.disp_cs && bus.disp_wen) begin
         case (disp_addr_e'(bus.disp_addr))
            DISP_ADDR_WORD: data_nxt        = bus.disp_wdata;
            DISP_ADDR_LO:   data_nxt[15:0]  = bus.disp_wdata[15:0];
            DISP_ADDR_HI:   data_nxt[31:16] = bus.disp_wdata[15:0];
            default:        data_nxt        = data_q;
         endcase
      end
   end

   // A digit is a leading zero when it and every more significant nibble are zero.
   assign nibble = data_q[{digit_idx, 2'b00} +: 4];
   assign blank  = blank_en && (digit_idx != '0) &&
                   ((data_q >> {digit_idx, 2'b00}) == '0);

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (seg_enc)
   );

   always_comb begin
      digit_sel_nxt = NUM_DIGITS'(1) << digit_idx;
      seg_nxt       = blank ? 8'h00 : seg_enc;
   end

   assign bus.disp_data = data_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboard bench for seg7_display_driver with SCAN_DIV=4: directed writes push
// expected {digit_sel, seg} per output edge; a negedge monitor pops and compares.
module tb_seg7_display_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       blank_en = 1'b0;
   logic [7:0] digit_sel;
   logic [7:0] seg;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   typedef struct {
      int         edge_n;
      logic [7:0] sel;
      logic [7:0] seg;
   } exp_t;

   exp_t exp_q[$];

   seg7_display_driver_if bus();

   seg7_display_driver #(.SCAN_DIV(4), .CNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .blank_en  (blank_en),
      .digit_sel (digit_sel),
      .seg       (seg)
   );

   always #5 clk = ~clk;

   // Edges since reset release; outputs after edge n show digit ((n-1)/4)%8.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && exp_q.size() > 0) begin
         if (exp_q[0].edge_n == cyc) begin
            e = exp_q.pop_front();
            nchk++;
            if (digit_sel !== e.sel || seg !== e.seg) begin
               nerr++;
               $display("FAIL scan@edge%0d: got sel=%h seg=%h, want sel=%h seg=%h",
                        cyc, digit_sel, seg, e.sel, e.seg);
            end
         end else if (exp_q[0].edge_n < cyc) begin
            e = exp_q.pop_front();
            nchk++;
            nerr++;
            $display("FAIL scan_missed: entry for edge %0d not checked, now at edge %0d",
                     e.edge_n, cyc);
         end
      end
   end

   task automatic push(input int e, input logic [7:0] s, input logic [7:0] g);
      exp_t x;
      x.edge_n = e;
      x.sel    = s;
      x.seg    = g;
      exp_q.push_back(x);
   endtask

   // segs packed {d7,...,d0}; holds = number of consecutive edges checked per digit.
   task automatic push_rot(input int start, input logic [63:0] segs, input int holds);
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < holds; j++)
            push(start + 4*k + j, 8'(1) << k, segs[8*k +: 8]);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      nchk++;
      if (cyc != n) begin
         nerr++;
         $display("FAIL sync: at edge %0d, want edge %0d", cyc, n);
      end
   endtask

   task automatic do_write(input logic cs, input logic wen, input logic [1:0] a,
                           input logic [31:0] d);
      bus.disp_cs    = cs;
      bus.disp_wen   = wen;
      bus.disp_addr  = a;
      bus.disp_wdata = d;
      @(negedge clk);
      bus.disp_cs    = 1'b0;
      bus.disp_wen   = 1'b0;
   endtask

   initial begin
      bus.disp_cs    = 1'b0;
      bus.disp_wen   = 1'b0;
      bus.disp_addr  = 2'b00;
      bus.disp_wdata = '0;

      #1;
      chk("rst_digit_sel", 32'(digit_sel), 32'h00);
      chk("rst_seg", 32'(seg), 32'h00);
      chk("rst_disp_data", bus.disp_data, 32'h0);

      @(negedge clk);
      push(1, 8'h01, 8'h3F);
      rst = 1'b1;

      // full word write, then one complete rotation with every hold edge checked
      wait_cyc(9);
      do_write(1'b1, 1'b1, 2'b00, 32'h1234ABCD);
      chk("wr_word", bus.disp_data, 32'h1234ABCD);
      push_rot(33, {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h77, 8'h7C, 8'h39, 8'h5E}, 4);
      push(65, 8'h01, 8'h5E);

      // half writes, reserved address and gated strobes
      wait_cyc(69);
      do_write(1'b1, 1'b1, 2'b01, 32'hFFFF0000);
      chk("wr_lo", bus.disp_data, 32'h12340000);
      do_write(1'b1, 1'b1, 2'b10, 32'h00005678);
      chk("wr_hi", bus.disp_data, 32'h56780000);
      do_write(1'b1, 1'b1, 2'b11, 32'hFFFFFFFF);
      chk("wr_rsvd", bus.disp_data, 32'h56780000);
      do_write(1'b1, 1'b0, 2'b00, 32'hDEADBEEF);
      chk("gate_wen", bus.disp_data, 32'h56780000);
      do_write(1'b0, 1'b1, 2'b00, 32'hDEADBEEF);
      chk("gate_cs", bus.disp_data, 32'h56780000);
      push_rot(97, {8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}, 1);

      // leading-zero blanking
      wait_cyc(129);
      blank_en = 1'b1;
      do_write(1'b1, 1'b1, 2'b00, 32'h00000A05);
      chk("wr_blank", bus.disp_data, 32'h00000A05);
      push_rot(161, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h3F, 8'h6D}, 1);

      wait_cyc(194);
      do_write(1'b1, 1'b1, 2'b00, 32'h00000000);
      chk("wr_zero", bus.disp_data, 32'h0);
      push_rot(225, 64'h3F, 1);

      wait_cyc(257);
      blank_en = 1'b0;
      push_rot(289, {8{8'h3F}}, 1);

      // write on the edge where digit 0 hands over to digit 1
      wait_cyc(323);
      push(324, 8'h01, 8'h3F);
      push(325, 8'h02, 8'h71);
      push(326, 8'h02, 8'h71);
      do_write(1'b1, 1'b1, 2'b00, 32'h000000F0);
      chk("wr_adv", bus.disp_data, 32'h000000F0);

      // asynchronous reset mid-scan
      wait_cyc(339);
      do_write(1'b1, 1'b1, 2'b00, 32'h1234ABCD);
      chk("wr_pre_rst", bus.disp_data, 32'h1234ABCD);
      wait_cyc(345);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_digit_sel", 32'(digit_sel), 32'h00);
      chk("async_rst_seg", 32'(seg), 32'h00);
      chk("async_rst_disp_data", bus.disp_data, 32'h0);
      @(negedge clk);
      chk("held_rst_digit_sel", 32'(digit_sel), 32'h00);
      push(1, 8'h01, 8'h3F);
      push(2, 8'h01, 8'h3F);
      push(5, 8'h02, 8'h3F);
      rst = 1'b1;
      wait_cyc(6);
      chk("post_rst_disp_data", bus.disp_data, 32'h0);

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: timeout at edge %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
